filt_sample_seq: RTL
====================

Name: filt_sample_seq

Overview:
Sequencer on the far side of the combinational diffEq filter core. It accepts ADC samples, maintains the x[n], x[n-1] and y[n-1] history registers that drive the core, and waits a fixed settle time. It then captures the core output as the new y[n-1] and hands it downstream to the DAC path over a valid/ready handshake. It sits between the ADC interface and the DAC interface in the guitar filter datapath.

Parameters:
N, 10, sample width in bits (unsigned offset-binary, midscale = 2^(N-1))
SETTLE, 2, clock cycles allowed for the combinational core to settle (legal range 1..15)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
clear  input  1  synchronous history/counter clear
in_valid  input  1  single-cycle sample strobe from ADC; source does not wait
in_sample  input  N  ADC sample, offset binary
in_ready  output  1  high when a strobe will be accepted
filt_x  output  2xN  [0]=x[n], [1]=x[n-1] to filter core
filt_y  output  N  y[n-1] to filter core
filt_out  input  N  filter core result
out_valid  output  1  out_sample holds a new result
out_ready  input  1  downstream accepts
out_sample  output  N  registered filter result
overrun_cnt  output  8  dropped-strobe count, saturating

Behaviour:
- Reset (async, reset_n=0): state IDLE; filt_x[0], filt_x[1], filt_y and out_sample = 2^(N-1) (512 at N=10); out_valid=0; overrun_cnt=0; settle counter=0. in_ready=1 once released.
- States:
  - IDLE: in_ready=1. On in_valid: filt_x[1]<=filt_x[0]; filt_x[0]<=in_sample; counter<=SETTLE-1; go to SETTLE.
  - SETTLE: in_ready=0. Counter decrements each cycle. At counter==0: out_sample<=filt_out; filt_y<=filt_out; out_valid<=1; go to HOLD.
  - HOLD: in_ready=0; out_valid=1; out_sample stable. When out_valid & out_ready: out_valid<=0; go to IDLE.
- Latency: strobe sampled at edge E; out_valid high from edge E+SETTLE onward. Minimum accepted sample period with out_ready tied high is SETTLE+2 cycles.
- filt_x and filt_y change only at the accept edge and the capture edge. Between those edges the core inputs are stable.
- Overrun: in_valid=1 while in_ready=0 discards the sample, leaves history untouched, and increments overrun_cnt. overrun_cnt saturates at 255 and never wraps.
- HOLD with out_ready=1 and in_valid=1 in the same cycle: in_ready is 0, so the strobe is dropped and counted.
- clear (synchronous) has priority over all other events. It applies the full reset state except that reset_n stays released. A clear during SETTLE or HOLD aborts the result: no out_valid is produced. A simultaneous in_valid is neither accepted nor counted.
- Arithmetic: no arithmetic on samples; registers are pure capture. The counter is 4 bits wide.
- out_valid never drops without a handshake, except on clear or reset.

Decomposition:
- Package filt_pkg:
  - state enum (IDLE, SETTLE, HOLD)
  - midscale function of N
  - LPF/HPF filter-type constants shared with the diffEq core
- No sub-module inside filt_sample_seq. A separate top wrapper, filt_channel, pairs it with diffEq and the f/fs/filt_type controls.

Test Plan:
- Reset, with N=10 and filt_out looped to filt_x[0] -> filt_x={512,512}, filt_y=512, out_valid=0, in_ready=1, overrun_cnt=0.
- Strobe 700 at edge E, out_ready=1 -> filt_x[0]=700, filt_x[1]=512, out_valid high from edge E+2, out_sample=700, filt_y=700, in_ready high again at E+3.
- Second strobe 300 -> filt_x[0]=300, filt_x[1]=700, filt_y=700 during SETTLE; out_sample=300.
- out_ready low for 6 cycles in HOLD with 3 strobes -> out_sample stable, history unchanged, overrun_cnt=3; result accepted once out_ready rises.
- 300 dropped strobes -> overrun_cnt=255, and it stays at 255.
- clear asserted in SETTLE, and separately reset_n pulsed in HOLD -> all history=512, out_valid=0, no result emitted, state IDLE.

Source files
------------

// File: rtl/filt_pkg.sv
// Shared types and constants for the guitar filter datapath.
// Used by the sample sequencer and the diffEq core wrapper.
package filt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } seq_state_t;

  localparam logic FT_LPF = 1'b0;
  localparam logic FT_HPF = 1'b1;

  localparam int CNT_W = 4;
  localparam int OVR_W = 8;

  function automatic int midscale(int n);
    return 1 << (n - 1);
  endfunction

endpackage

// File: rtl/filt_sample_seq.sv
// Sample sequencer: holds x/y history for the diffEq core, waits
// for it to settle, then hands the result to the DAC side.
module filt_sample_seq
  import filt_pkg::*;
#(
  parameter int N      = 10,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [N-1:0]        in_sample,
  output logic                in_ready,
  output logic [1:0][N-1:0]   filt_x,
  output logic [N-1:0]        filt_y,
  input  logic [N-1:0]        filt_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        out_sample,
  output logic [OVR_W-1:0]    overrun_cnt
);

  localparam int         MID_I  = midscale(N);
  localparam logic [N-1:0] MID  = MID_I[N-1:0];
  localparam int         INIT_I = SETTLE - 1;
  localparam logic [CNT_W-1:0] CNT_INIT = INIT_I[CNT_W-1:0];
  localparam logic [OVR_W-1:0] OVR_MAX  = '1;

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             drop;

  // strobes arriving while busy are lost; the source never waits
  assign drop = in_valid & ~in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      in_ready    <= 1'b1;
      filt_x[0]   <= MID;
      filt_x[1]   <= MID;
      filt_y      <= MID;
      out_sample  <= MID;
      out_valid   <= 1'b0;
      overrun_cnt <= '0;
    end else if (clear) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      in_ready    <= 1'b1;
      filt_x[0]   <= MID;
      filt_x[1]   <= MID;
      filt_y      <= MID;
      out_sample  <= MID;
      out_valid   <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      if (drop && overrun_cnt != OVR_MAX)
        overrun_cnt <= overrun_cnt + 1'b1;

      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            filt_x[1] <= filt_x[0];
            filt_x[0] <= in_sample;
            cnt       <= CNT_INIT;
            in_ready  <= 1'b0;
            state     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            out_sample <= filt_out;
            filt_y     <= filt_out;
            out_valid  <= 1'b1;
            state      <= ST_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
